// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: reset PC, FSM states and the buffered
// instruction entry carried from memory response to decoder.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0200_0000;
  localparam int unsigned XLEN             = 32;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
    logic            fault;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry instruction buffer with flush, registered head and a
// next-cycle occupancy output used by the fetch request throttle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  output logic                         head_valid,
  output fetch_entry_t                 head_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count_next_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, rd_ptr_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n, wr_idx;
  logic [CW-1:0] cnt, cnt_n;
  logic          do_push;
  fetch_entry_t  head_n;
  fetch_entry_t  head_q;
  logic          head_valid_q;

  // Flush clears first, so a push in the flush cycle lands in an empty buffer.
  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_idx   = wr_ptr;
    cnt_n    = cnt;
    do_push  = 1'b0;
    head_n   = '0;
    if (flush) begin
      rd_ptr_n = '0;
      wr_idx   = '0;
      cnt_n    = '0;
    end else if (pop && (cnt != '0)) begin
      rd_ptr_n = rd_ptr + AW'(1);
      cnt_n    = cnt - CW'(1);
    end
    if (push && (cnt_n < CW'(DEPTH))) begin
      do_push = 1'b1;
      cnt_n   = cnt_n + CW'(1);
    end
    wr_ptr_n = do_push ? (wr_idx + AW'(1)) : wr_idx;
    if (cnt_n != '0) begin
      head_n = (do_push && (wr_idx == rd_ptr_n)) ? push_entry : mem[rd_ptr_n];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_idx] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      cnt          <= '0;
      head_q       <= '0;
      head_valid_q <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr_n;
      wr_ptr       <= wr_ptr_n;
      cnt          <= cnt_n;
      head_q       <= head_n;
      head_valid_q <= (cnt_n != '0);
    end
  end

  assign head_valid   = head_valid_q;
  assign head_entry   = head_q;
  assign count_next_c = cnt_n;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, throttles word fetches against buffer space,
// discards stale responses after redirects and turns bus errors into faults.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction_code,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  fetch_state_t  state, state_n;
  logic [31:0]   pc, pc_n;
  logic [CW-1:0] outstanding, outstanding_n;
  logic [CW-1:0] discard, discard_n;
  logic [31:0]   shadow [DEPTH];
  logic [AW-1:0] sh_wr, sh_rd;
  logic          req_valid_q, req_valid_n;
  logic          req_acc;
  logic          rsp_keep;
  logic          redirect_misaligned;
  logic          fifo_push;
  logic          fifo_pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic          head_valid;
  logic [CW-1:0] fifo_count_n;

  assign req_acc             = req_valid_q & imem_req_ready;
  assign redirect_misaligned = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign rsp_keep            = imem_rsp_valid & ~redirect_valid & (discard == '0) & (state == FETCH);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_n;
    end
  end

  // Next state: a kept error response halts; any redirect overrides.
  always_comb begin
    state_n = state;
    case (state)
      FETCH: if (rsp_keep && imem_rsp_err) state_n = HALT;
      HALT:  state_n = HALT;
      default: state_n = FETCH;
    endcase
    if (redirect_valid) begin
      state_n = redirect_misaligned ? HALT : FETCH;
    end
  end

  // Request valid for next cycle, from next-cycle occupancy of the whole loop.
  always_comb begin
    req_valid_n = (state_n == FETCH) &&
                  (({1'b0, outstanding_n} + {1'b0, fifo_count_n}) < SW'(DEPTH));
  end

  // PC, in-flight and stale-response bookkeeping.
  always_comb begin
    pc_n          = pc;
    outstanding_n = outstanding + CW'(req_acc) - CW'(imem_rsp_valid);
    discard_n     = discard;
    if (redirect_valid) begin
      pc_n      = align_word(redirect_pc);
      discard_n = outstanding_n;
    end else begin
      if (req_acc) pc_n = pc + 32'd4;
      if (imem_rsp_valid && (discard != '0)) discard_n = discard - CW'(1);
    end
  end

  // Buffer write: a misaligned redirect enqueues its own fault entry.
  always_comb begin
    fifo_push  = redirect_misaligned | rsp_keep;
    push_entry = '0;
    if (redirect_valid) begin
      push_entry.pc    = redirect_pc;
      push_entry.data  = '0;
      push_entry.fault = 1'b1;
    end else begin
      push_entry.pc    = shadow[sh_rd];
      push_entry.data  = imem_rsp_err ? '0 : imem_rsp_data;
      push_entry.fault = imem_rsp_err;
    end
  end

  assign fifo_pop = head_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (req_acc) begin
      shadow[sh_wr] <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      sh_wr       <= '0;
      sh_rd       <= '0;
      req_valid_q <= 1'b0;
    end else begin
      pc          <= pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      sh_wr       <= sh_wr + AW'(req_acc);
      sh_rd       <= sh_rd + AW'(imem_rsp_valid);
      req_valid_q <= req_valid_n;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (redirect_valid),
    .push        (fifo_push),
    .push_entry  (push_entry),
    .pop         (fifo_pop),
    .head_valid  (head_valid),
    .head_entry  (head),
    .count_next_c(fifo_count_n)
  );

  assign imem_req_valid   = req_valid_q;
  assign imem_req_addr    = pc;
  assign inst_valid       = head_valid;
  assign instruction_code = head.data;
  assign inst_pc          = head.pc;
  assign inst_fault       = head.fault;

endmodule
